// File: rtl/rpg_pkg.sv
// -----------------------------------------------------------------------------
// rpg_pkg -- shared definitions for the playfield and its movers.
//
// Contents:
//   * playfield geometry: 20x15 grid of 32-pixel blocks whose top-left pixel
//     is (144, 31); the playable pixel range is h 144..783, v 31..510
//   * dir_e   : heading encoding (0 up, 1 right, 2 down, 3 left)
//   * state_e : enemy FSM encoding (0 idle, 1 patrol, 2 chase, 3 stun)
//   * COLLISION_MAP : 300-bit wall matrix, bit index = row*20 + col
//   * probe_point / step_point : pixel helpers used by the enemy mover
// -----------------------------------------------------------------------------
package rpg_pkg;

    localparam int GRID_COLS   = 20;
    localparam int GRID_ROWS   = 15;
    localparam int GRID_CELLS  = GRID_COLS * GRID_ROWS;
    localparam int BLOCK_SIZE  = 32;
    localparam int BLOCK_SHIFT = 5;

    localparam logic [9:0] FIELD_H_MIN = 10'd144;
    localparam logic [9:0] FIELD_H_MAX = 10'd783;
    localparam logic [9:0] FIELD_V_MIN = 10'd31;
    localparam logic [9:0] FIELD_V_MAX = 10'd510;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PATROL = 2'd1,
        ST_CHASE  = 2'd2,
        ST_STUN   = 2'd3
    } state_e;

    // Level layout: a solid border, one post in row 1 at column 12, a
    // horizontal bar in row 6 (columns 5..9) and a vertical bar in column 15
    // (rows 3..10).
    function automatic logic is_wall_cell(input int row, input int col);
        logic w;
        w = 1'b0;
        if (row == 0 || row == GRID_ROWS - 1) w = 1'b1;
        if (col == 0 || col == GRID_COLS - 1) w = 1'b1;
        if (row == 1 && col == 12) w = 1'b1;
        if (row == 6 && col >= 5 && col <= 9) w = 1'b1;
        if (col == 15 && row >= 3 && row <= 10) w = 1'b1;
        return w;
    endfunction

    function automatic logic [GRID_CELLS-1:0] build_collision_map();
        logic [GRID_CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                m[r*GRID_COLS + c] = is_wall_cell(r, c);
            end
        end
        return m;
    endfunction

    localparam logic [GRID_CELLS-1:0] COLLISION_MAP = build_collision_map();

    // Single pixel just beyond the 32x32 sprite in heading d, after a move
    // of 'step' pixels. The probe sits on the sprite's centre line.
    function automatic logic [19:0] probe_point(input logic [9:0] h,
                                                input logic [9:0] v,
                                                input dir_e       d,
                                                input logic [9:0] step);
        logic [19:0] p;
        case (d)
            DIR_UP:    p = {h + 10'd16, v - step};
            DIR_RIGHT: p = {h + 10'd31 + step, v + 10'd16};
            DIR_DOWN:  p = {h + 10'd16, v + 10'd31 + step};
            default:   p = {h - step, v + 10'd16};
        endcase
        return p;
    endfunction

    // Sprite position after moving 'step' pixels in heading d.
    function automatic logic [19:0] step_point(input logic [9:0] h,
                                               input logic [9:0] v,
                                               input dir_e       d,
                                               input logic [9:0] step);
        logic [19:0] p;
        case (d)
            DIR_UP:    p = {h, v - step};
            DIR_RIGHT: p = {h + step, v};
            DIR_DOWN:  p = {h, v + step};
            default:   p = {h - step, v};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/wall_lookup.sv
// -----------------------------------------------------------------------------
// wall_lookup -- combinational probe of the collision matrix.
//
// Ports:
//   probe_h [9:0] : in  horizontal pixel of the probe
//   probe_v [9:0] : in  vertical pixel of the probe
//   wall          : out 1 when the pixel is outside the playfield or lies in
//                       a wall block
// -----------------------------------------------------------------------------
module wall_lookup
    import rpg_pkg::*;
(
    input  logic [9:0] probe_h,
    input  logic [9:0] probe_v,
    output logic       wall
);

    logic       in_field;
    logic [9:0] h_off;
    logic [9:0] v_off;
    logic [4:0] col;
    logic [4:0] row;
    logic [8:0] idx;

    always_comb begin
        in_field = (probe_h >= FIELD_H_MIN) && (probe_h <= FIELD_H_MAX) &&
                   (probe_v >= FIELD_V_MIN) && (probe_v <= FIELD_V_MAX);
        h_off = probe_h - FIELD_H_MIN;
        v_off = probe_v - FIELD_V_MIN;
        col   = 5'(h_off >> BLOCK_SHIFT);
        row   = 5'(v_off >> BLOCK_SHIFT);
        idx   = '0;
        wall  = 1'b1;
        // The index is only meaningful inside the field; outside it the
        // probe is a wall regardless of the matrix contents.
        if (in_field) begin
            idx  = 9'(row) * 9'(GRID_COLS) + 9'(col);
            wall = COLLISION_MAP[idx];
        end
    end

endmodule

// File: rtl/enemy_patrol.sv
// -----------------------------------------------------------------------------
// enemy_patrol -- enemy sprite mover with patrol / chase / stun behaviour.
//
// Parameters:
//   START_H, START_V : reset position (pixels)
//   STEP             : pixels moved per move step
//   SPEED_DIV        : tick pulses per move step (1..15)
//   CHASE_R          : per-axis range that triggers a chase; chase is dropped
//                      when either axis distance reaches 2*CHASE_R
//   STUN_STEPS       : move steps spent frozen after a hit (>= 1)
//
// Ports:
//   clk             : in  clock, all state on its rising edge
//   rst             : in  synchronous active-high reset
//   tick            : in  one-cycle movement enable (frame rate)
//   player_position : in  {hpos[19:10], vpos[9:0]} of the player
//   player_hit      : in  player/enemy contact flag
//   e_position      : out {hpos, vpos} of this enemy (registered)
//   e_dir           : out current heading (0 up, 1 right, 2 down, 3 left)
//   e_state         : out current FSM state code (debug visibility)
//
// A move step is a tick that arrives when the prescaler sits at SPEED_DIV-1.
// All outputs change one cycle after the cycle that qualifies them.
// -----------------------------------------------------------------------------
module enemy_patrol
    import rpg_pkg::*;
#(
    parameter int START_H    = 208,
    parameter int START_V    = 63,
    parameter int STEP       = 2,
    parameter int SPEED_DIV  = 3,
    parameter int CHASE_R    = 64,
    parameter int STUN_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [19:0] player_position,
    input  logic        player_hit,
    output logic [19:0] e_position,
    output logic [1:0]  e_dir,
    output logic [1:0]  e_state
);

    localparam logic [3:0]  PRESC_LAST = 4'(SPEED_DIV - 1);
    localparam logic [7:0]  STUN_LAST  = 8'(STUN_STEPS - 1);
    localparam logic [9:0]  STEP_PX    = 10'(STEP);
    localparam logic [10:0] NEAR_R     = 11'(CHASE_R);
    localparam logic [10:0] FAR_R      = 11'(2 * CHASE_R);

    state_e      state_q, state_d;
    dir_e        dir_q, dir_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [3:0]  presc_q, presc_d;
    logic [7:0]  stun_q, stun_d;

    logic [9:0]        ply_h, ply_v;
    logic signed [10:0] dh, dv;
    logic [10:0]       abs_dh, abs_dv;
    logic              h_major;
    dir_e              h_toward, v_toward;
    dir_e              pri_dir, sec_dir, probe_dir;
    logic              pri_nz, sec_nz;
    logic              near, far;
    logic              move_step;
    logic [19:0]       probe_a, probe_b;
    logic              wall_a, wall_b;

    // ------------------------------------------------------------------
    // Player-relative geometry and probe selection
    // ------------------------------------------------------------------
    always_comb begin
        ply_h  = player_position[19:10];
        ply_v  = player_position[9:0];
        dh     = $signed({1'b0, ply_h}) - $signed({1'b0, h_q});
        dv     = $signed({1'b0, ply_v}) - $signed({1'b0, v_q});
        abs_dh = dh[10] ? $unsigned(-dh) : $unsigned(dh);
        abs_dv = dv[10] ? $unsigned(-dv) : $unsigned(dv);

        near = (abs_dh < NEAR_R) && (abs_dv < NEAR_R);
        far  = (abs_dh >= FAR_R) || (abs_dv >= FAR_R);

        // Horizontal axis wins ties.
        h_major  = (abs_dh >= abs_dv);
        h_toward = dh[10] ? DIR_LEFT : DIR_RIGHT;
        v_toward = dv[10] ? DIR_UP : DIR_DOWN;
        pri_dir  = h_major ? h_toward : v_toward;
        sec_dir  = h_major ? v_toward : h_toward;
        pri_nz   = h_major ? (abs_dh != '0) : (abs_dv != '0);
        sec_nz   = h_major ? (abs_dv != '0) : (abs_dh != '0);

        // The primary lookup serves the patrol heading outside of chase.
        probe_dir = (state_q == ST_CHASE) ? pri_dir : dir_q;
        probe_a   = probe_point(h_q, v_q, probe_dir, STEP_PX);
        probe_b   = probe_point(h_q, v_q, sec_dir, STEP_PX);

        move_step = tick && (presc_q == PRESC_LAST);
    end

    wall_lookup u_wall_pri (
        .probe_h (probe_a[19:10]),
        .probe_v (probe_a[9:0]),
        .wall    (wall_a)
    );

    wall_lookup u_wall_sec (
        .probe_h (probe_b[19:10]),
        .probe_v (probe_b[9:0]),
        .wall    (wall_b)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        h_d     = h_q;
        v_d     = v_q;
        presc_d = presc_q;
        stun_d  = stun_q;

        // The prescaler is parked in IDLE so the first patrol step lands a
        // full SPEED_DIV ticks after leaving it. It keeps counting in STUN
        // because stun duration is measured in move steps.
        if (state_q != ST_IDLE && tick) begin
            presc_d = move_step ? 4'd0 : presc_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_PATROL;
                end
            end

            ST_PATROL: begin
                if (player_hit) begin
                    state_d = ST_STUN;
                    stun_d  = '0;
                end else if (move_step) begin
                    // Acquiring the player consumes the step; movement
                    // toward the player begins on the next one.
                    if (near) begin
                        state_d = ST_CHASE;
                    end else if (!wall_a) begin
                        {h_d, v_d} = step_point(h_q, v_q, dir_q, STEP_PX);
                    end else begin
                        dir_d = dir_e'(dir_q + 2'd1);
                    end
                end
            end

            ST_CHASE: begin
                if (player_hit) begin
                    state_d = ST_STUN;
                    stun_d  = '0;
                end else if (move_step) begin
                    if (far) begin
                        state_d = ST_PATROL;
                    end else if (pri_nz && !wall_a) begin
                        {h_d, v_d} = step_point(h_q, v_q, pri_dir, STEP_PX);
                        dir_d      = pri_dir;
                    end else if (sec_nz && !wall_b) begin
                        {h_d, v_d} = step_point(h_q, v_q, sec_dir, STEP_PX);
                        dir_d      = sec_dir;
                    end
                end
            end

            ST_STUN: begin
                if (move_step) begin
                    if (stun_q == STUN_LAST) begin
                        stun_d = '0;
                        // A hit on the exit step restarts the stun instead.
                        if (!player_hit) begin
                            state_d = ST_PATROL;
                        end
                    end else begin
                        stun_d = stun_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            h_q     <= 10'(START_H);
            v_q     <= 10'(START_V);
            presc_q <= '0;
            stun_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            h_q     <= h_d;
            v_q     <= v_d;
            presc_q <= presc_d;
            stun_q  <= stun_d;
        end
    end

    assign e_position = {h_q, v_q};
    assign e_dir      = dir_q;
    assign e_state    = state_q;

endmodule
